// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port unified memory between the instruction-fetch (IF)
// stage and the load/store (MEM) stage of a 5-stage pipeline. Each access is
// sequenced through a mem_req/mem_ready handshake. While an access is pending
// the requester sees its stall output high; completion is signalled by a
// one-cycle valid pulse carrying the registered result.
//
// Arbitration: data accesses win, except when a fetch is pending and the data
// side has already been granted MAX_DATA_RUN times in a row while that fetch
// waited. In that case the fetch wins.
//
// Robustness: an access that sees no mem_ready for TIMEOUT request cycles is
// abandoned. The valid pulse is issued with a zero result and the sticky
// bus_err flag is raised. A branch redirect (if_flush) during a fetch lets
// the memory cycle finish but suppresses the result.
//
// Parameters
//   XLEN          data and address width
//   MAX_DATA_RUN  max consecutive data grants while a fetch is pending
//   TIMEOUT       request cycles without mem_ready before abort (8-bit count)
//
// Ports
//   clk, reset             clock; synchronous active-high reset
//   if_req/if_addr         fetch request and PC
//   if_flush               discard the in-flight fetch
//   if_stall               if_req & ~if_valid (combinational)
//   if_valid/if_instr      fetch completion pulse and registered word
//   d_memread/d_memwrite   load/store request from the MEM stage
//   d_addr/d_wdata         load/store address and store data
//   d_stall                (d_memread|d_memwrite) & ~d_valid (combinational)
//   d_valid/d_rdata        data completion pulse and registered load result
//   mem_req/mem_we         memory request (held until mem_ready) and write enable
//   mem_addr/mem_wdata     registered address and write data
//   mem_rdata/mem_ready    memory read data and completion strobe
//   bus_err                sticky timeout flag, cleared only by reset
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int XLEN         = 32,
  parameter int MAX_DATA_RUN = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic            clk,
  input  logic            reset,

  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  input  logic            if_flush,
  output logic            if_stall,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,

  input  logic            d_memread,
  input  logic            d_memwrite,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic            d_stall,
  output logic            d_valid,
  output logic [XLEN-1:0] d_rdata,

  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,

  output logic            bus_err
);

  localparam int RUN_W = (MAX_DATA_RUN < 1) ? 1 : $clog2(MAX_DATA_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(MAX_DATA_RUN);
  localparam logic [7:0]       TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    FETCH = 2'd2
  } state_t;

  // Run counter stops at MAX_DATA_RUN so the fetch-turn compare stays exact.
  function automatic logic [RUN_W-1:0] run_sat_inc(input logic [RUN_W-1:0] v);
    return (v == RUN_MAX) ? v : v + RUN_W'(1);
  endfunction

  state_t            state, state_nxt;
  logic [RUN_W-1:0]  run_cnt, run_nxt;
  logic [7:0]        tmo_cnt, tmo_nxt;
  logic              drop, drop_nxt;

  logic              mem_req_nxt;
  logic              mem_we_nxt;
  logic [XLEN-1:0]   mem_addr_nxt;
  logic [XLEN-1:0]   mem_wdata_nxt;
  logic              if_valid_nxt;
  logic [XLEN-1:0]   if_instr_nxt;
  logic              d_valid_nxt;
  logic [XLEN-1:0]   d_rdata_nxt;
  logic              bus_err_nxt;

  logic              d_any;
  logic              d_req;
  logic              f_req;
  logic              fetch_turn;
  logic              grant_data;
  logic              grant_fetch;
  logic              drop_now;

  assign d_any    = d_memread | d_memwrite;
  assign d_stall  = d_any & ~d_valid;
  assign if_stall = if_req & ~if_valid;

  // Masking with the valid pulse keeps a requester from being re-granted in
  // the same cycle its previous access is reported complete.
  assign d_req = d_any & ~d_valid;
  assign f_req = if_req & ~if_valid & ~if_flush;

  assign fetch_turn  = f_req & (run_cnt == RUN_MAX);
  assign grant_data  = d_req & ~fetch_turn;
  assign grant_fetch = f_req & ~grant_data;

  // A flush in the completing cycle counts as well as an earlier one.
  assign drop_now = drop | if_flush;

  // ---- arbitration / access sequencing (next-state) ----
  always_comb begin
    state_nxt     = state;
    run_nxt       = run_cnt;
    tmo_nxt       = tmo_cnt;
    drop_nxt      = drop;
    mem_req_nxt   = mem_req;
    mem_we_nxt    = mem_we;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    if_valid_nxt  = 1'b0;
    if_instr_nxt  = if_instr;
    d_valid_nxt   = 1'b0;
    d_rdata_nxt   = d_rdata;
    bus_err_nxt   = bus_err;

    case (state)
      IDLE: begin
        drop_nxt = 1'b0;
        if (grant_data) begin
          state_nxt     = DATA;
          mem_req_nxt   = 1'b1;
          // A simultaneous read+write request is treated as a write.
          mem_we_nxt    = d_memwrite;
          mem_addr_nxt  = d_addr;
          mem_wdata_nxt = d_wdata;
          tmo_nxt       = 8'd0;
          // The run only accumulates while a fetch is actually waiting.
          run_nxt       = f_req ? run_sat_inc(run_cnt) : '0;
        end else if (grant_fetch) begin
          state_nxt     = FETCH;
          mem_req_nxt   = 1'b1;
          mem_we_nxt    = 1'b0;
          mem_addr_nxt  = if_addr;
          mem_wdata_nxt = '0;
          tmo_nxt       = 8'd0;
          run_nxt       = '0;
        end
      end

      DATA: begin
        if (mem_ready) begin
          d_rdata_nxt = mem_we ? '0 : mem_rdata;
          d_valid_nxt = 1'b1;
          mem_req_nxt = 1'b0;
          mem_we_nxt  = 1'b0;
          state_nxt   = IDLE;
        end else if (tmo_cnt == TMO_LAST) begin
          bus_err_nxt = 1'b1;
          d_rdata_nxt = '0;
          d_valid_nxt = 1'b1;
          mem_req_nxt = 1'b0;
          mem_we_nxt  = 1'b0;
          state_nxt   = IDLE;
        end else begin
          tmo_nxt = tmo_cnt + 8'd1;
        end
      end

      FETCH: begin
        drop_nxt = drop_now;
        if (mem_ready) begin
          if (!drop_now) begin
            if_instr_nxt = mem_rdata;
            if_valid_nxt = 1'b1;
          end
          mem_req_nxt = 1'b0;
          drop_nxt    = 1'b0;
          state_nxt   = IDLE;
        end else if (tmo_cnt == TMO_LAST) begin
          bus_err_nxt = 1'b1;
          if (!drop_now) begin
            if_instr_nxt = '0;
            if_valid_nxt = 1'b1;
          end
          mem_req_nxt = 1'b0;
          drop_nxt    = 1'b0;
          state_nxt   = IDLE;
        end else begin
          tmo_nxt = tmo_cnt + 8'd1;
        end
      end

      default: begin
        state_nxt   = IDLE;
        mem_req_nxt = 1'b0;
        mem_we_nxt  = 1'b0;
        drop_nxt    = 1'b0;
      end
    endcase
  end

  // ---- state and output registers ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      run_cnt   <= '0;
      tmo_cnt   <= 8'd0;
      drop      <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_valid  <= 1'b0;
      if_instr  <= '0;
      d_valid   <= 1'b0;
      d_rdata   <= '0;
      bus_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      run_cnt   <= run_nxt;
      tmo_cnt   <= tmo_nxt;
      drop      <= drop_nxt;
      mem_req   <= mem_req_nxt;
      mem_we    <= mem_we_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      if_valid  <= if_valid_nxt;
      if_instr  <= if_instr_nxt;
      d_valid   <= d_valid_nxt;
      d_rdata   <= d_rdata_nxt;
      bus_err   <= bus_err_nxt;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter (MAX_DATA_RUN=4, TIMEOUT=8). A table of
// per-cycle {inputs, expected outputs} records covers zero-wait fetch, a
// simultaneous store+fetch and a one-wait load. Hand-written sequences cover
// the run limit, flush during a wait-stated fetch, completion in the timeout
// cycle, timeout, and reset in the middle of an access.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling
// edge.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam logic Y = 1'b1;
  localparam logic N = 1'b0;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        if_stall;
  logic        if_valid;
  logic [31:0] if_instr;
  logic        d_memread;
  logic        d_memwrite;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_stall;
  logic        d_valid;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        bus_err;

  int n_chk  = 0;
  int n_fail = 0;

  mem_port_arbiter #(
    .XLEN         (32),
    .MAX_DATA_RUN (4),
    .TIMEOUT      (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_flush   (if_flush),
    .if_stall   (if_stall),
    .if_valid   (if_valid),
    .if_instr   (if_instr),
    .d_memread  (d_memread),
    .d_memwrite (d_memwrite),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_stall    (d_stall),
    .d_valid    (d_valid),
    .d_rdata    (d_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .bus_err    (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        d_memread;
    logic        d_memwrite;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        e_if_stall;
    logic        e_if_valid;
    logic [31:0] e_if_instr;
    logic        e_d_stall;
    logic        e_d_valid;
    logic [31:0] e_d_rdata;
    logic        e_mem_req;
    logic        e_mem_we;
    logic [31:0] e_mem_addr;
    logic [31:0] e_mem_wdata;
  } vec_t;

  vec_t tbl [15];

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", nm, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic clr_in();
    if_req     = 1'b0;
    if_addr    = 32'h0;
    if_flush   = 1'b0;
    d_memread  = 1'b0;
    d_memwrite = 1'b0;
    d_addr     = 32'h0;
    d_wdata    = 32'h0;
    mem_rdata  = 32'h0;
    mem_ready  = 1'b0;
  endtask

  int got_g [$];
  int exp_g [11];

  initial begin
    // inputs: if_req if_addr if_flush d_memread d_memwrite d_addr d_wdata mem_rdata mem_ready
    // expect: if_stall if_valid if_instr d_stall d_valid d_rdata mem_req mem_we mem_addr mem_wdata
    // zero-wait fetch
    tbl[0]  = '{Y, 32'h100, N, N, N, 32'h0, 32'h0, 32'h0, N,
                Y, N, 32'h0, N, N, 32'h0, N, N, 32'h0, 32'h0};
    tbl[1]  = '{Y, 32'h100, N, N, N, 32'h0, 32'h0, 32'h00500093, Y,
                Y, N, 32'h0, N, N, 32'h0, Y, N, 32'h100, 32'h0};
    tbl[2]  = '{Y, 32'h100, N, N, N, 32'h0, 32'h0, 32'h0, N,
                N, Y, 32'h00500093, N, N, 32'h0, N, N, 32'h0, 32'h0};
    tbl[3]  = '{N, 32'h0, N, N, N, 32'h0, 32'h0, 32'h0, N,
                N, N, 32'h00500093, N, N, 32'h0, N, N, 32'h0, 32'h0};
    // store and fetch together: store first, fetch granted in the d_valid cycle
    tbl[4]  = '{Y, 32'h104, N, N, Y, 32'h2000, 32'hDEADBEEF, 32'h0, N,
                Y, N, 32'h00500093, Y, N, 32'h0, N, N, 32'h0, 32'h0};
    tbl[5]  = '{Y, 32'h104, N, N, Y, 32'h2000, 32'hDEADBEEF, 32'hFFFFFFFF, Y,
                Y, N, 32'h00500093, Y, N, 32'h0, Y, Y, 32'h2000, 32'hDEADBEEF};
    tbl[6]  = '{Y, 32'h104, N, N, Y, 32'h2000, 32'hDEADBEEF, 32'h0, N,
                Y, N, 32'h00500093, N, Y, 32'h0, N, N, 32'h0, 32'h0};
    tbl[7]  = '{Y, 32'h104, N, N, N, 32'h0, 32'h0, 32'h12345678, Y,
                Y, N, 32'h00500093, N, N, 32'h0, Y, N, 32'h104, 32'h0};
    tbl[8]  = '{Y, 32'h104, N, N, N, 32'h0, 32'h0, 32'h0, N,
                N, Y, 32'h12345678, N, N, 32'h0, N, N, 32'h0, 32'h0};
    tbl[9]  = '{N, 32'h0, N, N, N, 32'h0, 32'h0, 32'h0, N,
                N, N, 32'h12345678, N, N, 32'h0, N, N, 32'h0, 32'h0};
    // load with one wait state
    tbl[10] = '{N, 32'h0, N, Y, N, 32'h3000, 32'h0, 32'h0, N,
                N, N, 32'h12345678, Y, N, 32'h0, N, N, 32'h0, 32'h0};
    tbl[11] = '{N, 32'h0, N, Y, N, 32'h3000, 32'h0, 32'h0, N,
                N, N, 32'h12345678, Y, N, 32'h0, Y, N, 32'h3000, 32'h0};
    tbl[12] = '{N, 32'h0, N, Y, N, 32'h3000, 32'h0, 32'hCAFEF00D, Y,
                N, N, 32'h12345678, Y, N, 32'h0, Y, N, 32'h3000, 32'h0};
    tbl[13] = '{N, 32'h0, N, Y, N, 32'h3000, 32'h0, 32'h0, N,
                N, N, 32'h12345678, N, Y, 32'hCAFEF00D, N, N, 32'h0, 32'h0};
    tbl[14] = '{N, 32'h0, N, N, N, 32'h0, 32'h0, 32'h0, N,
                N, N, 32'h12345678, N, N, 32'hCAFEF00D, N, N, 32'h0, 32'h0};

    // 0 = data grant, 1 = fetch grant
    exp_g = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1};

    // ---------------- reset values ----------------
    clr_in();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    sample();
    chk1 ("rst mem_req",   mem_req,   1'b0);
    chk1 ("rst mem_we",    mem_we,    1'b0);
    chk32("rst mem_addr",  mem_addr,  32'h0);
    chk32("rst mem_wdata", mem_wdata, 32'h0);
    chk1 ("rst if_valid",  if_valid,  1'b0);
    chk1 ("rst d_valid",   d_valid,   1'b0);
    chk32("rst if_instr",  if_instr,  32'h0);
    chk32("rst d_rdata",   d_rdata,   32'h0);
    chk1 ("rst bus_err",   bus_err,   1'b0);
    tick();
    reset = 1'b0;

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < 15; i++) begin
      if_req     = tbl[i].if_req;
      if_addr    = tbl[i].if_addr;
      if_flush   = tbl[i].if_flush;
      d_memread  = tbl[i].d_memread;
      d_memwrite = tbl[i].d_memwrite;
      d_addr     = tbl[i].d_addr;
      d_wdata    = tbl[i].d_wdata;
      mem_rdata  = tbl[i].mem_rdata;
      mem_ready  = tbl[i].mem_ready;
      sample();
      chk1 ($sformatf("v%0d if_stall", i), if_stall, tbl[i].e_if_stall);
      chk1 ($sformatf("v%0d if_valid", i), if_valid, tbl[i].e_if_valid);
      chk32($sformatf("v%0d if_instr", i), if_instr, tbl[i].e_if_instr);
      chk1 ($sformatf("v%0d d_stall", i),  d_stall,  tbl[i].e_d_stall);
      chk1 ($sformatf("v%0d d_valid", i),  d_valid,  tbl[i].e_d_valid);
      chk32($sformatf("v%0d d_rdata", i),  d_rdata,  tbl[i].e_d_rdata);
      chk1 ($sformatf("v%0d mem_req", i),  mem_req,  tbl[i].e_mem_req);
      chk1 ($sformatf("v%0d bus_err", i),  bus_err,  1'b0);
      if (tbl[i].e_mem_req) begin
        chk1 ($sformatf("v%0d mem_we", i),   mem_we,   tbl[i].e_mem_we);
        chk32($sformatf("v%0d mem_addr", i), mem_addr, tbl[i].e_mem_addr);
        if (tbl[i].e_mem_we)
          chk32($sformatf("v%0d mem_wdata", i), mem_wdata, tbl[i].e_mem_wdata);
      end
      tick();
    end

    // ---------------- run limit ----------------
    // Loads are re-requested continuously with a fetch held pending. A redirect
    // in each d_valid cycle keeps the fetch from taking that free slot, so the
    // data side builds a run: 4 data grants, then the fetch. The first data
    // grant after the fetch sees no pending fetch (if_valid) and restarts the run.
    clr_in();
    for (int s = 0; s < 32; s++) begin
      if_req    = (s < 31);
      if_addr   = 32'h500;
      d_memread = (s < 31);
      d_addr    = 32'h4000;
      if_flush  = (s == 2)  || (s == 5)  || (s == 8)  || (s == 11) || (s == 16) ||
                  (s == 19) || (s == 22) || (s == 25) || (s == 28);
      mem_ready = 1'b1;
      mem_rdata = 32'h00000013;
      sample();
      if (mem_req) got_g.push_back((mem_addr == 32'h500) ? 1 : 0);
      tick();
    end
    chk32("run grant count", 32'(got_g.size()), 32'd11);
    for (int i = 0; i < 11; i++)
      if (i < got_g.size())
        chk32($sformatf("run grant %0d is_fetch", i), 32'(got_g[i]), 32'(exp_g[i]));

    // ---------------- flush during a 3-wait-state fetch ----------------
    clr_in();
    if_req    = 1'b1;
    if_addr   = 32'h600;
    mem_rdata = 32'hAAAA5555;
    sample();
    chk1("fl f0 mem_req", mem_req, 1'b0);
    chk1("fl f0 if_stall", if_stall, 1'b1);
    tick();
    sample();
    chk1 ("fl f1 mem_req", mem_req, 1'b1);
    chk32("fl f1 mem_addr", mem_addr, 32'h600);
    chk1 ("fl f1 mem_we", mem_we, 1'b0);
    tick();
    if_flush = 1'b1;
    sample();
    chk1("fl f2 mem_req", mem_req, 1'b1);
    tick();
    if_flush = 1'b0;
    sample();
    chk1("fl f3 mem_req", mem_req, 1'b1);
    tick();
    mem_ready = 1'b1;
    sample();
    chk1("fl f4 mem_req", mem_req, 1'b1);
    tick();
    mem_ready = 1'b0;
    if_addr   = 32'h700;
    sample();
    chk1 ("fl f5 if_valid", if_valid, 1'b0);
    chk32("fl f5 if_instr", if_instr, 32'h00000013);
    chk1 ("fl f5 mem_req", mem_req, 1'b0);
    chk1 ("fl f5 if_stall", if_stall, 1'b1);
    tick();
    mem_ready = 1'b1;
    mem_rdata = 32'h11112222;
    sample();
    chk1 ("fl f6 mem_req", mem_req, 1'b1);
    chk32("fl f6 mem_addr", mem_addr, 32'h700);
    tick();
    mem_ready = 1'b0;
    sample();
    chk1 ("fl f7 if_valid", if_valid, 1'b1);
    chk32("fl f7 if_instr", if_instr, 32'h11112222);
    tick();
    if_req = 1'b0;
    sample();
    chk1("fl f8 if_valid", if_valid, 1'b0);
    tick();

    // ---------------- mem_ready in the cycle a timeout would fire ----------------
    clr_in();
    d_memread = 1'b1;
    d_addr    = 32'h9000;
    sample();
    chk1("rt a0 mem_req", mem_req, 1'b0);
    chk1("rt a0 d_stall", d_stall, 1'b1);
    tick();
    for (int k = 1; k <= 8; k++) begin
      mem_ready = (k == 8);
      mem_rdata = 32'h5A5A5A5A;
      sample();
      chk1($sformatf("rt a%0d mem_req", k), mem_req, 1'b1);
      tick();
    end
    mem_ready = 1'b0;
    sample();
    chk1 ("rt a9 d_valid", d_valid, 1'b1);
    chk32("rt a9 d_rdata", d_rdata, 32'h5A5A5A5A);
    chk1 ("rt a9 bus_err", bus_err, 1'b0);
    chk1 ("rt a9 mem_req", mem_req, 1'b0);
    tick();
    d_memread = 1'b0;
    sample();
    chk1("rt a10 d_valid", d_valid, 1'b0);
    chk1("rt a10 bus_err", bus_err, 1'b0);
    tick();

    // ---------------- timeout on a load ----------------
    clr_in();
    d_memread = 1'b1;
    d_addr    = 32'h8000;
    mem_rdata = 32'h77777777;
    sample();
    chk1 ("to t0 mem_req", mem_req, 1'b0);
    chk32("to t0 d_rdata", d_rdata, 32'h5A5A5A5A);
    tick();
    for (int k = 1; k <= 8; k++) begin
      sample();
      chk1($sformatf("to t%0d mem_req", k), mem_req, 1'b1);
      chk1($sformatf("to t%0d bus_err", k), bus_err, 1'b0);
      tick();
    end
    sample();
    chk1 ("to t9 mem_req", mem_req, 1'b0);
    chk1 ("to t9 d_valid", d_valid, 1'b1);
    chk32("to t9 d_rdata", d_rdata, 32'h0);
    chk1 ("to t9 bus_err", bus_err, 1'b1);
    chk1 ("to t9 d_stall", d_stall, 1'b0);
    tick();
    d_memread = 1'b0;
    sample();
    chk1("to t10 bus_err", bus_err, 1'b1);
    chk1("to t10 d_valid", d_valid, 1'b0);
    tick();
    sample();
    chk1("to t11 bus_err", bus_err, 1'b1);
    tick();

    // ---------------- reset in the second wait state of a load ----------------
    clr_in();
    d_memread = 1'b1;
    d_addr    = 32'hA000;
    sample();
    chk1("rs r0 bus_err", bus_err, 1'b1);
    tick();
    sample();
    chk1("rs r1 mem_req", mem_req, 1'b1);
    tick();
    reset = 1'b1;
    sample();
    chk1("rs r2 mem_req", mem_req, 1'b1);
    tick();
    reset     = 1'b0;
    d_memread = 1'b0;
    sample();
    chk1 ("rs r3 mem_req",   mem_req,   1'b0);
    chk1 ("rs r3 mem_we",    mem_we,    1'b0);
    chk32("rs r3 mem_addr",  mem_addr,  32'h0);
    chk32("rs r3 mem_wdata", mem_wdata, 32'h0);
    chk1 ("rs r3 if_valid",  if_valid,  1'b0);
    chk1 ("rs r3 d_valid",   d_valid,   1'b0);
    chk32("rs r3 if_instr",  if_instr,  32'h0);
    chk32("rs r3 d_rdata",   d_rdata,   32'h0);
    chk1 ("rs r3 bus_err",   bus_err,   1'b0);
    chk1 ("rs r3 d_stall",   d_stall,   1'b0);
    tick();
    sample();
    chk1("rs r4 d_valid", d_valid, 1'b0);
    chk1("rs r4 mem_req", mem_req, 1'b0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port unified memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage pipeline. It sequences each access through a request/ready handshake and raises per-requester stall signals until the access completes. Those stalls feed the hazard logic, which turns stalled slots into NOPs through the CU `stall` input. Data accesses have priority, with a run-limit so fetch cannot starve.

## Interface
- `XLEN`, 32: data and address width.
- `MAX_DATA_RUN`, 4: maximum consecutive data grants while a fetch is pending.
- `TIMEOUT`, 255: number of `mem_req` cycles without `mem_ready` before the access is aborted. 8-bit counter.

Ports (name, direction, width, meaning):
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `if_req`  in  1  IF stage requests a fetch; held until `if_valid`.
- `if_addr`  in  XLEN  fetch address (PC).
- `if_flush`  in  1  branch redirect; discard the in-flight fetch.
- `if_stall`  out  1  `if_req & ~if_valid` (combinational).
- `if_valid`  out  1  one-cycle pulse: `if_instr` holds the fetched word.
- `if_instr`  out  XLEN  registered fetch result.
- `d_memread`  in  1  load request from the MEM stage (CU `memread` path).
- `d_memwrite`  in  1  store request from the MEM stage (CU `memwrite` path).
- `d_addr`  in  XLEN  load/store address.
- `d_wdata`  in  XLEN  store data.
- `d_stall`  out  1  `(d_memread|d_memwrite) & ~d_valid` (combinational).
- `d_valid`  out  1  one-cycle pulse: the data access is complete.
- `d_rdata`  out  XLEN  registered load result. Reads 0 after a store.
- `mem_req`  out  1  memory request; held until `mem_ready`.
- `mem_we`  out  1  write enable; valid while `mem_req` is high.
- `mem_addr`  out  XLEN  registered address.
- `mem_wdata`  out  XLEN  registered write data.
- `mem_rdata`  in  XLEN  read data; valid in the `mem_ready` cycle.
- `mem_ready`  in  1  access complete; ignored while `mem_req` is low.
- `bus_err`  out  1  sticky timeout flag; cleared only by `reset`.

## Operation
- FSM states: IDLE, DATA, FETCH.
- Reset values: state IDLE. These outputs are 0: `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `if_valid`, `d_valid`, `if_instr`, `d_rdata`, `bus_err`. Run counter, timeout counter and drop flag are also 0.

IDLE arbitration:
- Effective data request: `d_req = (d_memread|d_memwrite) & ~d_valid`.
- Effective fetch request: `f_req = if_req & ~if_valid & ~if_flush`.
- Masking by the valid pulse prevents re-granting a requester in the same cycle its completion is seen.
- Data wins, unless `f_req` is high and the run counter equals `MAX_DATA_RUN`; then fetch wins.

Granting:
- On a grant, the address, write data and `mem_we` are latched, and `mem_req` rises on the next edge.
- If `d_memread` and `d_memwrite` are both high, the access is a write (`mem_we=1`).
- The run counter increments on each data grant (saturating), and clears on a fetch grant or when no fetch is pending at a data grant.

DATA / FETCH states:
- `mem_req` is held high with stable `mem_addr`, `mem_we` and `mem_wdata`.
- On a `mem_ready` edge: capture `mem_rdata` into `d_rdata` (0 for a write) or `if_instr`, drop `mem_req`, pulse the matching valid on the next cycle, and return to IDLE.

Flush:
- `if_flush` at any cycle during FETCH sets the drop flag.
- The memory transaction still completes (it cannot be aborted), but `if_valid` is suppressed and `if_instr` is not updated.
- The drop flag clears on return to IDLE.

Timeout:
- The timeout counter counts cycles with `mem_req` high and is cleared on grant.
- Reaching `TIMEOUT` without `mem_ready`: drop `mem_req`, set `bus_err`, pulse the valid with result data 0, return to IDLE. The pipeline never hangs.

Reset mid-access: state returns to IDLE and `mem_req` is low after that edge. The in-flight result is discarded and no valid pulse is issued.

## Timing
- Zero-wait memory (`mem_ready` in the first `mem_req` cycle):
  - Request seen in cycle 0, `mem_req` high in cycle 1, valid pulse in cycle 2.
  - Stall is high in cycles 0-1 and low in cycle 2.
  - The requester advances at the end of cycle 2.
- N wait states add N cycles.
- The earliest next grant is in the valid-pulse cycle (IDLE), to the other requester; the same requester's next request is arbitrated one cycle later.
- With back-to-back data requests and a pending fetch, fetch is granted after at most `MAX_DATA_RUN` data grants.
- `mem_ready` arriving in the cycle a timeout would fire counts as a normal completion; `bus_err` is not set.

## Test plan
- Zero-wait fetch only: `if_req=1`, `if_addr=0x100`, `mem_rdata=0x00500093` -> `mem_req` in cycle 1 with `mem_addr=0x100`, `mem_we=0`; `if_valid` in cycle 2 with `if_instr=0x00500093`; `if_stall` high in cycles 0-1.
- Simultaneous requests: `if_req=1` and `d_memwrite=1`, `d_addr=0x2000`, `d_wdata=0xDEADBEEF` -> store granted first (`mem_we=1`, `mem_addr=0x2000`); the fetch is granted in the `d_valid` cycle; `if_stall` is held throughout.
- Starvation limit: `d_memread` continuously re-requested and `if_req=1` with `MAX_DATA_RUN=4` -> exactly 4 data grants, then a fetch grant, then the run counter clears.
- Flush during a 3-wait-state fetch (`if_flush` pulse in the second `mem_req` cycle) -> transaction completes; no `if_valid`; `if_instr` unchanged; the next fetch uses the new `if_addr`.
- Timeout with `TIMEOUT=8` and `mem_ready` held 0 on a load -> `mem_req` drops after 8 cycles; `bus_err=1`; `d_valid` pulses with `d_rdata=0`; `bus_err` stays 1 until `reset`.
- Reset asserted mid-DATA (wait state 2) -> next cycle: `mem_req=0`, state IDLE, no `d_valid`, all outputs at their reset values.
